// File: rtl/mc6847_attr_renderer.sv
// mc6847_attr_renderer: MC6847 text/SG4 renderer with per-character attribute sampling
// Ports: PIX_CLK/RESET clock and sync reset; frame_start/line_start timing strobes;
// AG bitmap-mode latch input; AS/INV/EXT/CSS per-character attributes; RD/DA/DD VRAM port;
// FONT_ADDR/FONT_DATA font ROM port; PIX_VALID/PIX_COLOR colour-index pixel stream.
module mc6847_attr_renderer #(
    parameter int COLS      = 32,
    parameter int ROWS      = 16,
    parameter int CHAR_H    = 12,
    parameter int HSCALE    = 2,
    parameter int VSCALE    = 2,
    parameter int ADDR_W    = 15,
    parameter int VRAM_BASE = 0
) (
    input  logic              PIX_CLK,
    input  logic              RESET,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              AG,
    input  logic              AS,
    input  logic              INV,
    input  logic              EXT,
    input  logic              CSS,
    output logic              RD,
    output logic [ADDR_W-1:0] DA,
    input  logic [7:0]        DD,
    output logic [10:0]       FONT_ADDR,
    input  logic [7:0]        FONT_DATA,
    output logic              PIX_VALID,
    output logic [3:0]        PIX_COLOR
);
    localparam int P      = 8 * HSCALE;
    localparam int ACTIVE = ROWS * CHAR_H * VSCALE;
    localparam int LW     = $clog2(ACTIVE + 1) + 1;
    localparam int CW     = $clog2(P);
    localparam int HW     = (HSCALE > 1) ? $clog2(HSCALE) : 1;
    localparam int COLW   = (COLS > 1) ? $clog2(COLS) : 1;

    logic [LW-1:0]   lcnt, cur, row_c, frow_c;
    logic            ag_q, ag_c, armed, go, run;
    logic [3:0]      frow_q;
    logic            upper_q;
    logic [CW-1:0]   cyc;
    logic [COLW-1:0] col;
    logic            ld, c_as, c_inv;
    logic [7:0]      c_sg;
    logic [3:0]      c_fg;
    logic [7:0]      sh;
    logic [3:0]      sfg;
    logic            sv;
    logic [HW-1:0]   hcnt;
    logic [2:0]      bcnt;
    logic            unused_dd7;

    assign unused_dd7 = DD[7];

    // frame_start acts before a coincident line_start, so that line is line 0
    always_comb begin
        cur    = frame_start ? '0 : lcnt;
        ag_c   = frame_start ? AG : ag_q;
        go     = line_start && (armed || frame_start) && !ag_c && (cur < LW'(ACTIVE));
        row_c  = cur / LW'(CHAR_H * VSCALE);
        frow_c = (cur / LW'(VSCALE)) % LW'(CHAR_H);
    end

    always_ff @(posedge PIX_CLK) begin
        if (RESET) begin
            lcnt    <= '0;
            ag_q    <= 1'b0;
            armed   <= 1'b0;
            frow_q  <= '0;
            upper_q <= 1'b0;
        end else begin
            if (frame_start) begin
                ag_q  <= AG;
                armed <= 1'b1;
            end
            if (line_start) begin
                lcnt    <= (&cur) ? cur : cur + 1'b1;
                frow_q  <= 4'(frow_c);
                upper_q <= frow_c < LW'(CHAR_H / 2);
            end else if (frame_start) begin
                lcnt <= '0;
            end
        end
    end

    // cell sequencer: one VRAM read every P cycles, COLS reads per line
    always_ff @(posedge PIX_CLK) begin
        if (RESET) begin
            run <= 1'b0;
            cyc <= '0;
            col <= '0;
            RD  <= 1'b0;
            DA  <= '0;
        end else begin
            RD <= 1'b0;
            if (line_start) begin
                run <= go;
                cyc <= '0;
                col <= '0;
                RD  <= go;
                if (go) DA <= ADDR_W'(32'(row_c) * COLS + VRAM_BASE);
            end else if (run) begin
                if (cyc == CW'(P - 1)) begin
                    cyc <= '0;
                    if (col == COLW'(COLS - 1)) begin
                        run <= 1'b0;
                    end else begin
                        col <= col + 1'b1;
                        RD  <= 1'b1;
                        DA  <= DA + 1'b1;
                    end
                end else begin
                    cyc <= cyc + 1'b1;
                end
            end
        end
    end

    // cell register: data and attributes captured together the cycle after RD
    always_ff @(posedge PIX_CLK) begin
        if (RESET) begin
            ld        <= 1'b0;
            FONT_ADDR <= '0;
            c_as      <= 1'b0;
            c_inv     <= 1'b0;
            c_fg      <= '0;
            c_sg      <= '0;
        end else begin
            ld <= RD && !line_start;
            if (RD) begin
                FONT_ADDR <= {EXT, DD[5:0], frow_q};
                c_as      <= AS;
                c_inv     <= INV ^ DD[6];
                c_fg      <= AS ? {1'b0, DD[6:4]} : (CSS ? 4'd7 : 4'd0);
                c_sg      <= upper_q ? {{4{DD[3]}}, {4{DD[2]}}} : {{4{DD[1]}}, {4{DD[0]}}};
            end
        end
    end

    // pixel shifter plus registered output stage
    always_ff @(posedge PIX_CLK) begin
        if (RESET) begin
            sv        <= 1'b0;
            sh        <= '0;
            sfg       <= '0;
            hcnt      <= '0;
            bcnt      <= '0;
            PIX_VALID <= 1'b0;
            PIX_COLOR <= '0;
        end else begin
            PIX_VALID <= sv;
            PIX_COLOR <= sv ? (sh[7] ? sfg : 4'd8) : 4'd0;
            if (line_start) begin
                sv <= 1'b0;
            end else if (ld) begin
                sv   <= 1'b1;
                sh   <= c_as ? c_sg : FONT_DATA ^ {8{c_inv}};
                sfg  <= c_fg;
                hcnt <= '0;
                bcnt <= '0;
            end else if (sv) begin
                if (hcnt == HW'(HSCALE - 1)) begin
                    hcnt <= '0;
                    sh   <= {sh[6:0], 1'b0};
                    bcnt <= bcnt + 1'b1;
                    if (bcnt == 3'd7) sv <= 1'b0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mc6847_attr_renderer.sv
// tb_mc6847_attr_renderer: directed self-checking bench for mc6847_attr_renderer
module tb_mc6847_attr_renderer;
    logic        PIX_CLK = 1'b0;
    logic        RESET, frame_start, line_start, AG, AS, INV, EXT, CSS;
    logic        RD;
    logic [14:0] DA;
    logic [7:0]  DD;
    logic [10:0] FONT_ADDR;
    logic [7:0]  FONT_DATA;
    logic        PIX_VALID;
    logic [3:0]  PIX_COLOR;
    int          tests = 0;
    int          fails = 0;

    mc6847_attr_renderer dut (
        .PIX_CLK(PIX_CLK), .RESET(RESET), .frame_start(frame_start), .line_start(line_start),
        .AG(AG), .AS(AS), .INV(INV), .EXT(EXT), .CSS(CSS), .RD(RD), .DA(DA), .DD(DD),
        .FONT_ADDR(FONT_ADDR), .FONT_DATA(FONT_DATA), .PIX_VALID(PIX_VALID), .PIX_COLOR(PIX_COLOR)
    );

    always #5 PIX_CLK = ~PIX_CLK;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge PIX_CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic ag);
        frame_start = 1'b1;
        AG = ag;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic line();
        line_start = 1'b1;
        step(1);
        line_start = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; frame_start = 0; line_start = 0; AG = 0;
        AS = 0; INV = 0; EXT = 0; CSS = 0; DD = 8'h00; FONT_DATA = 8'h00;
        step(2);
        chk("rst_rd", 32'(RD), 0);
        chk("rst_da", 32'(DA), 0);
        chk("rst_fa", 32'(FONT_ADDR), 0);
        chk("rst_pv", 32'(PIX_VALID), 0);
        chk("rst_pc", 32'(PIX_COLOR), 0);
        RESET = 1'b0;
        line();
        chk("noframe_rd", 32'(RD), 0);

        // alphanumeric line 0
        DD = 8'h01; FONT_DATA = 8'h80;
        frame(1'b0);
        line();
        chk("t1_rd0", 32'(RD), 1);
        chk("t1_da0", 32'(DA), 32'h0000);
        step(1);
        chk("t1_rd1", 32'(RD), 0);
        chk("t1_fa", 32'(FONT_ADDR), 32'h010);
        step(1);
        chk("t1_pv2", 32'(PIX_VALID), 0);
        step(1);
        chk("t1_pv3", 32'(PIX_VALID), 1);
        chk("t1_pc3", 32'(PIX_COLOR), 0);
        step(1);
        chk("t1_pc4", 32'(PIX_COLOR), 0);
        step(1);
        chk("t1_pc5", 32'(PIX_COLOR), 8);
        step(11);
        chk("t1_rd16", 32'(RD), 1);
        chk("t1_da16", 32'(DA), 32'h0001);
        step(2);
        chk("t1_pc18", 32'(PIX_COLOR), 8);
        step(1);
        chk("t1_pc19", 32'(PIX_COLOR), 0);
        chk("t1_pv19", 32'(PIX_VALID), 1);
        step(495);
        chk("t1_pv514", 32'(PIX_VALID), 1);
        chk("t1_pc514", 32'(PIX_COLOR), 8);
        step(1);
        chk("t1_pv515", 32'(PIX_VALID), 0);
        chk("t1_pc515", 32'(PIX_COLOR), 0);
        chk("t1_da_last", 32'(DA), 32'h001F);
        step(20);
        chk("t1_no_rd", 32'(RD), 0);
        chk("t1_da_hold", 32'(DA), 32'h001F);

        // rows: lines 24 and 25
        for (int i = 1; i < 24; i++) line();
        line();
        chk("t2_rd24", 32'(RD), 1);
        chk("t2_da24", 32'(DA), 32'h0020);
        step(1);
        chk("t2_fa24", 32'(FONT_ADDR), 32'h010);
        line();
        chk("t2_da25", 32'(DA), 32'h0020);
        step(1);
        chk("t2_fa25", 32'(FONT_ADDR[3:0]), 0);

        // SG4 upper and lower halves
        AS = 1'b1; DD = 8'h5A;
        frame(1'b0);
        line();
        step(3);
        chk("t3u_pc3", 32'(PIX_COLOR), 5);
        step(7);
        chk("t3u_pc10", 32'(PIX_COLOR), 5);
        step(1);
        chk("t3u_pc11", 32'(PIX_COLOR), 8);
        step(7);
        chk("t3u_pc18", 32'(PIX_COLOR), 8);
        step(1);
        chk("t3u_pc19", 32'(PIX_COLOR), 5);
        EXT = 1'b1;
        for (int i = 1; i < 12; i++) line();
        line();
        step(1);
        chk("t3l_fa", 32'(FONT_ADDR), 32'h5A6);
        step(2);
        chk("t3l_pc3", 32'(PIX_COLOR), 5);
        step(7);
        chk("t3l_pc10", 32'(PIX_COLOR), 5);
        step(1);
        chk("t3l_pc11", 32'(PIX_COLOR), 8);
        step(7);
        chk("t3l_pc18", 32'(PIX_COLOR), 8);

        // attribute changes at cell boundaries
        AS = 1'b0; EXT = 1'b0; INV = 1'b0; CSS = 1'b0; DD = 8'h41; FONT_DATA = 8'h00;
        frame(1'b0);
        line();
        step(3);
        chk("t4_pc3", 32'(PIX_COLOR), 0);
        step(2);
        CSS = 1'b1; INV = 1'b1;
        chk("t4_pc5", 32'(PIX_COLOR), 0);
        step(13);
        chk("t4_pc18", 32'(PIX_COLOR), 0);
        step(1);
        chk("t4_pc19", 32'(PIX_COLOR), 8);
        step(1);
        INV = 1'b0;
        step(15);
        chk("t4_pc35", 32'(PIX_COLOR), 7);

        // line_start abort at T+100
        step(64);
        chk("t5_da99", 32'(DA), 32'h0006);
        line();
        chk("t5_rd100", 32'(RD), 1);
        chk("t5_da100", 32'(DA), 32'h0000);
        step(1);
        chk("t5_pv101", 32'(PIX_VALID), 0);
        step(2);
        chk("t5_pv103", 32'(PIX_VALID), 1);

        // AG latched high
        frame(1'b1);
        line();
        chk("t6_ag_rd", 32'(RD), 0);
        step(3);
        chk("t6_ag_pv", 32'(PIX_VALID), 0);

        // last active line and first inactive line
        frame(1'b0);
        for (int i = 0; i < 383; i++) line();
        line();
        chk("t6_rd383", 32'(RD), 1);
        chk("t6_da383", 32'(DA), 32'h01E0);
        line();
        chk("t6_rd384", 32'(RD), 0);
        step(3);
        chk("t6_pv384", 32'(PIX_VALID), 0);

        // reset mid-line
        frame(1'b0);
        line();
        step(49);
        RESET = 1'b1;
        step(1);
        RESET = 1'b0;
        step(1);
        chk("t6_rst_rd", 32'(RD), 0);
        chk("t6_rst_da", 32'(DA), 0);
        chk("t6_rst_fa", 32'(FONT_ADDR), 0);
        chk("t6_rst_pv", 32'(PIX_VALID), 0);
        chk("t6_rst_pc", 32'(PIX_COLOR), 0);
        step(16);
        chk("t6_rst_nord", 32'(RD), 0);
        line();
        chk("t6_rst_line_rd", 32'(RD), 0);
        frame(1'b0);
        line();
        chk("t6_rearm_rd", 32'(RD), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
